// File: rtl/boot_loader.sv
// boot_loader
// ------------
// Program loader that sits in front of the processor core. After reset it
// holds the core in reset and receives a framed image over a byte
// valid/ready stream:
//   LEN_LO, LEN_HI             16-bit word count N (little-endian)
//   N x 4 payload bytes        each word LSB first -> wdata = {b3,b2,b1,b0}
//   checksum byte              sum mod 256 of all payload bytes
// Every assembled word is written to instruction memory as a one-cycle
// strobe. A matching checksum releases the core. A bad count or a bad
// checksum leaves the core held in reset and raises err.
//
// Ports
//   clk, rst     clock and synchronous active-high reset
//   rx_valid     byte present on rx_data
//   rx_data      stream byte
//   rx_ready     loader accepts a byte this cycle
//   imem_we      instruction-memory write strobe (one cycle per word)
//   imem_addr    word address of the write
//   imem_wdata   word to write
//   core_rst     core reset (1 = held in reset)
//   done         image loaded and verified, core running
//   err          image rejected
module boot_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // One extra bit so MAX_WORDS = 65536 still compares correctly.
  localparam logic [16:0] MAX_COUNT = 17'(MAX_WORDS);

  // Modulo-256 checksum accumulation.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    csum_add = acc + b;
  endfunction

  state_t            state_r;
  state_t            next_state_s;
  logic              accept_s;
  logic [15:0]       count_s;
  logic              count_bad_s;
  logic              last_byte_s;
  logic              last_word_s;
  logic [7:0]        len_lo_r;
  logic [ADDR_W-1:0] last_idx_r;
  logic [ADDR_W-1:0] word_idx_r;
  logic [1:0]        byte_idx_r;
  logic [7:0]        sum_r;
  logic [23:0]       lane_r;

  assign accept_s    = rx_valid && rx_ready;
  // The full count is only meaningful while the high byte is on rx_data.
  assign count_s     = {rx_data, len_lo_r};
  assign count_bad_s = (count_s == 16'd0) || ({1'b0, count_s} > MAX_COUNT);
  assign last_byte_s = (byte_idx_r == 2'd3);
  assign last_word_s = (word_idx_r == last_idx_r);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_LEN0;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_LEN0: begin
        if (accept_s) next_state_s = S_LEN1;
        else          next_state_s = S_LEN0;
      end
      S_LEN1: begin
        if (accept_s) next_state_s = count_bad_s ? S_ERR : S_DATA;
        else          next_state_s = S_LEN1;
      end
      S_DATA: begin
        if (accept_s && last_byte_s && last_word_s) next_state_s = S_CSUM;
        else                                        next_state_s = S_DATA;
      end
      S_CSUM: begin
        if (accept_s) next_state_s = (rx_data == sum_r) ? S_RUN : S_ERR;
        else          next_state_s = S_CSUM;
      end
      S_RUN:   next_state_s = S_RUN;
      S_ERR:   next_state_s = S_ERR;
      // An illegal encoding must never release the core.
      default: next_state_s = S_ERR;
    endcase
  end

  // Header capture, word assembly, checksum and memory write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo_r   <= 8'd0;
      last_idx_r <= {ADDR_W{1'b0}};
      word_idx_r <= {ADDR_W{1'b0}};
      byte_idx_r <= 2'd0;
      sum_r      <= 8'd0;
      lane_r     <= 24'd0;
      imem_we    <= 1'b0;
      imem_addr  <= {ADDR_W{1'b0}};
      imem_wdata <= 32'd0;
    end else begin
      imem_we <= 1'b0;
      if (accept_s) begin
        case (state_r)
          S_LEN0: len_lo_r <= rx_data;
          S_LEN1: begin
            // N-1 fits ADDR_W whenever the count is legal; otherwise unused.
            last_idx_r <= ADDR_W'(count_s - 16'd1);
            word_idx_r <= {ADDR_W{1'b0}};
          end
          S_DATA: begin
            sum_r      <= csum_add(sum_r, rx_data);
            byte_idx_r <= byte_idx_r + 2'd1;
            case (byte_idx_r)
              2'd0:    lane_r[7:0]   <= rx_data;
              2'd1:    lane_r[15:8]  <= rx_data;
              2'd2:    lane_r[23:16] <= rx_data;
              default: begin
                imem_we    <= 1'b1;
                imem_addr  <= word_idx_r;
                imem_wdata <= {rx_data, lane_r};
                // Hold at N-1 so the index never runs past the image.
                if (!last_word_s) word_idx_r <= word_idx_r + ADDR_W'(1'b1);
              end
            endcase
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Status outputs registered from the next state so they change with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ready <= 1'b1;
      core_rst <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      rx_ready <= (next_state_s == S_LEN0) || (next_state_s == S_LEN1) ||
                  (next_state_s == S_DATA) || (next_state_s == S_CSUM);
      core_rst <= (next_state_s != S_RUN);
      done     <= (next_state_s == S_RUN);
      err      <= (next_state_s == S_ERR);
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed frames from the test plan
// plus randomized frames, checked against a frame-level reference model.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        done;
  logic        err;

  boot_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  logic [39:0] got_q[$];
  int          got_t[$];
  logic [39:0] exp_q[$];
  logic [7:0]  frame_q[$];

  always @(posedge clk) cyc = cyc + 1;

  // Write monitor: one entry per cycle the strobe is seen high.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      got_q.push_back({imem_addr, imem_wdata});
      got_t.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input bit pending_byte);
    rst      = 1'b1;
    rx_valid = pending_byte;
    rx_data  = 8'h5A;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    chk("rst_core_rst", 64'(core_rst),   64'd1);
    chk("rst_rx_ready", 64'(rx_ready),   64'd1);
    chk("rst_we",       64'(imem_we),    64'd0);
    chk("rst_addr",     64'(imem_addr),  64'd0);
    chk("rst_wdata",    64'(imem_wdata), 64'd0);
    chk("rst_done",     64'(done),       64'd0);
    chk("rst_err",      64'(err),        64'd0);
    got_q.delete();
    got_t.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Build a random frame; bad counts produce a header-only frame.
  task automatic build_frame(input int n, input bit corrupt);
    logic [7:0] s;
    logic [7:0] b;
    frame_q.delete();
    frame_q.push_back(8'(n));
    frame_q.push_back(8'(n >> 8));
    if (n >= 1 && n <= 256) begin
      s = 8'd0;
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        frame_q.push_back(b);
        s = s + b;
      end
      frame_q.push_back(corrupt ? s + 8'($urandom_range(255, 1)) : s);
    end
  endtask

  // Send frame_q and compare writes and final status with the model.
  task automatic run_frame(input string tag, input int max_gap, input bit toggle);
    int         n;
    bit         hdr_bad;
    bit         exp_ok;
    logic [7:0] s;
    int         nw;
    n       = int'({frame_q[1], frame_q[0]});
    hdr_bad = (n == 0) || (n > 256);
    exp_ok  = 1'b0;
    exp_q.delete();
    if (!hdr_bad) begin
      s = 8'd0;
      for (int k = 0; k < n; k++) begin
        exp_q.push_back({8'(k), frame_q[2+4*k+3], frame_q[2+4*k+2],
                         frame_q[2+4*k+1], frame_q[2+4*k]});
        for (int j = 0; j < 4; j++) s = s + frame_q[2+4*k+j];
      end
      exp_ok = (frame_q[2+4*n] == s);
    end
    for (int i = 0; i < frame_q.size(); i++) begin
      if (i == frame_q.size() - 1 && !hdr_bad) begin
        chk({tag, "_pre_core_rst"}, 64'(core_rst), 64'd1);
        chk({tag, "_pre_done"},     64'(done),     64'd0);
      end
      send_byte(frame_q[i], toggle ? 1 : $urandom_range(max_gap, 0));
    end
    @(negedge clk);
    chk({tag, "_done"},     64'(done),     64'(exp_ok));
    chk({tag, "_err"},      64'(err),      64'(!exp_ok));
    chk({tag, "_core_rst"}, 64'(core_rst), 64'(!exp_ok));
    chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
    chk({tag, "_nwrites"},  64'(got_q.size()), 64'(exp_q.size()));
    nw = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < nw; k++) chk({tag, "_write"}, 64'(got_q[k]), 64'(exp_q[k]));
    if (max_gap == 0 && !toggle) begin
      for (int k = 1; k < got_t.size(); k++)
        chk({tag, "_spacing"}, 64'(got_t[k] - got_t[k-1]), 64'd4);
    end
    // Terminal state must ignore further traffic.
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
    @(negedge clk);
    chk({tag, "_post_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
    chk({tag, "_post_done"},    64'(done),         64'(exp_ok));
    chk({tag, "_post_err"},     64'(err),          64'(!exp_ok));
  endtask

  initial begin
    int kind;
    int n;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Reset values.
    do_reset(1'b0);

    // Good 2-word image, byte every cycle.
    frame_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h97};
    run_frame("good2", 0, 1'b0);
    chk("good2_n", 64'(got_q.size()), 64'd2);
    if (got_q.size() >= 2) begin
      chk("good2_w0", 64'(got_q[0]), 64'h00_00500093);
      chk("good2_w1", 64'(got_q[1]), 64'h01_00A00113);
    end

    // Bad checksum.
    do_reset(1'b0);
    frame_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h98};
    run_frame("badsum", 0, 1'b0);

    // Bad header: count 0 and count 257.
    do_reset(1'b0);
    frame_q = '{8'h00, 8'h00};
    run_frame("hdr0", 0, 1'b0);
    do_reset(1'b0);
    frame_q = '{8'h01, 8'h01};
    run_frame("hdr257", 0, 1'b0);

    // Throttled stream with junk between valid bytes.
    do_reset(1'b0);
    frame_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h97};
    run_frame("throttle", 0, 1'b1);

    // Reset mid-load after 5 payload bytes, with a byte offered during reset.
    do_reset(1'b0);
    for (int i = 0; i < 7; i++) send_byte(frame_q[i], 0);
    repeat (3) @(negedge clk);
    chk("midload_n", 64'(got_q.size()), 64'd1);
    if (got_q.size() >= 1) chk("midload_w0", 64'(got_q[0]), 64'h00_00500093);
    do_reset(1'b1);
    run_frame("resend", 0, 1'b0);

    // Largest legal image (word index reaches 255).
    do_reset(1'b0);
    build_frame(256, 1'b0);
    run_frame("max256", 0, 1'b0);

    // Randomized frames.
    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(4, 0);
      do_reset(it[0]);
      case (kind)
        0, 1:    begin n = $urandom_range(6, 1);       build_frame(n, 1'b0); end
        2:       begin n = $urandom_range(6, 1);       build_frame(n, 1'b1); end
        3:       begin n = 0;                          build_frame(n, 1'b0); end
        default: begin n = $urandom_range(65535, 257); build_frame(n, 1'b0); end
      endcase
      run_frame("rand", $urandom_range(2, 0), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
# boot_loader

Byte-stream program loader sitting directly upstream of the single-cycle processor core. Out of reset it holds the core in reset and accepts a framed program image over a byte valid/ready stream. It writes each assembled 32-bit little-endian word into instruction memory and verifies a checksum. On success it releases the core's `rst`; on failure it keeps the core held in reset.

## Interface

**Parameters**
- `ADDR_W`, default 8: instruction-memory word-address width.
- `MAX_WORDS`, default 256: largest accepted image, in words. Must satisfy `MAX_WORDS <= 2**ADDR_W`.

**Ports**
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rx_valid` input 1: byte present on `rx_data`.
- `rx_data` input 8: stream byte.
- `rx_ready` output 1: loader can accept a byte this cycle.
- `imem_we` output 1: instruction-memory write strobe, one cycle per word.
- `imem_addr` output ADDR_W: word address of the write.
- `imem_wdata` output 32: word to write.
- `core_rst` output 1: drives the core's `rst`; high holds the core in reset.
- `done` output 1: image loaded and verified; core running.
- `err` output 1: image rejected.

## Operation

- **Frame format:**
  - `LEN_LO`, `LEN_HI`: 16-bit word count N, little-endian.
  - N×4 payload bytes: each word sent LSB first, so `wdata = {b3,b2,b1,b0}`.
  - One checksum byte: sum modulo 256 of all payload bytes. Header bytes are excluded.
- **Byte acceptance:** a byte is accepted on a rising edge where `rx_valid && rx_ready`. Bytes with `rx_valid=0` are ignored. Gaps of any length are allowed.
- **States:**
  - `S_LEN0`: accept low count byte → `S_LEN1`.
  - `S_LEN1`: accept high count byte. If N==0 or N>MAX_WORDS → `S_ERR`; else → `S_DATA`.
  - `S_DATA`: accept payload bytes.
    - A 2-bit byte index selects the lane.
    - On the 4th byte of a word, issue a write and increment the word index.
    - After word N−1 is completed → `S_CSUM`.
  - `S_CSUM`: accept checksum byte. If equal to the running sum → `S_RUN`; else → `S_ERR`.
  - `S_RUN`: terminal. `done=1`, `core_rst=0`.
  - `S_ERR`: terminal. `err=1`, `core_rst=1`.
  - Terminal states are left only via `rst`.
- **`rx_ready`:** 1 in `S_LEN0`, `S_LEN1`, `S_DATA` and `S_CSUM`; 0 in `S_RUN` and `S_ERR`.
- **Arithmetic:**
  - Running sum: 8-bit register, wraps modulo 256, cleared on reset.
  - Word index: ADDR_W bits, starts at 0, never exceeds N−1.
- **Reset (any state, including mid-load):**
  - Return to `S_LEN0`.
  - Clear the sum, word index and byte index.
  - Memory contents already written are not cleared; the next load overwrites them.

## Timing

- **Reset values:** `core_rst=1`, `rx_ready=1` (state `S_LEN0`), `imem_we=0`, `imem_addr=0`, `imem_wdata=0`, `done=0`, `err=0`.
- **Write latency:** 4th byte of word k accepted at edge E → `imem_we=1` with `imem_addr=k` and `imem_wdata` assembled, for exactly the one cycle following E. Then `imem_we=0`.
- **Throughput:** one byte per cycle sustained. Back-to-back words produce write pulses 4 cycles apart.
- **Release timing:** checksum byte accepted at edge C → `core_rst`, `done` and `err` take their final values in the cycle after C.
  - The final word's write always completes no later than the cycle in which the checksum can be accepted.
  - The core therefore never leaves reset before the last write.
- **Header error:** a bad count accepted at edge H → `err=1` and `rx_ready=0` in the cycle after H. No writes occur.
- **Simultaneous reset:** `rst` high at an edge dominates any concurrent byte acceptance. That byte is discarded and no write pulse follows.

## Test plan

1. **Reset:** hold `rst` for 2 cycles. Required: `core_rst=1`, `rx_ready=1`, `imem_we=0`, `done=0`, `err=0`.
2. **Good 2-word image, byte every cycle:** send `02 00 93 00 50 00 13 01 A0 00 97`. Required:
   - Write addr 0 = `0x00500093`, then addr 1 = `0x00A00113`, each a single-cycle `imem_we` pulse.
   - Cycle after the checksum: `core_rst=0`, `done=1`, `rx_ready=0`.
3. **Bad checksum:** same image with final byte `98`. Required:
   - Both writes occur.
   - Then `err=1`, `core_rst` stays 1, `done=0`.
   - Further `rx_valid` is ignored.
4. **Bad header, count 0:** send `00 00`. Required: `err=1` the cycle after the 2nd byte, zero writes.
5. **Bad header, count too large:** with `MAX_WORDS=256`, send header `01 01` (N=257). Required: `err=1` the cycle after the 2nd byte, zero writes.
6. **Throttled stream:** test 2's image with `rx_valid` toggling every other cycle and junk on `rx_data` while invalid. Required: identical writes and `done=1`; only timing is stretched.
7. **Reset mid-load:** assert `rst` after 5 payload bytes of test 2, then resend the full image. Required:
   - One write (addr 0) before the reset; none from the partial second word.
   - After the resend, both words written correctly, `done=1`, `core_rst=0`.
